// File: rtl/first_signal_reporter.sv
// -----------------------------------------------------------------------------
// first_signal_reporter
//
// Purpose:
//   This block sits after the first-signal detector. It takes the detector's
//   locked capture y_in = {c,b,a} and produces one report per measurement
//   window, with a timestamp.
//
//   A window opens on a single-cycle start pulse. The block counts cycles
//   until y_in goes non-zero, or until TIMEOUT cycles pass with no signal.
//   It then encodes the winner with fixed priority a > b > c, flags a tie,
//   and holds the report on a valid/ready handshake until it is accepted.
//
// Parameters:
//   CNT_W    width of the arrival-time counter and rpt_time.
//   TIMEOUT  cycles in a window before a no-signal report is issued.
//            Legal range: 1 <= TIMEOUT <= 2**CNT_W - 1. Inside that range
//            the counter can never wrap.
//
// Ports:
//   clk         system clock; all logic runs on the rising edge
//   rst         synchronous, active-high reset
//   start       single-cycle request to open a window (honoured only in IDLE)
//   y_in[2:0]   detector capture {c,b,a}; the detector locks it once non-zero
//   rpt_valid   a report is being presented
//   rpt_ready   the consumer accepts the report on an edge where valid is high
//   rpt_winner  0 = timeout/none, 1 = a, 2 = b, 3 = c
//   rpt_tie     more than one bit is set in the captured mask
//   rpt_mask    raw captured y_in (0 on timeout)
//   rpt_time    cycles from window open to capture (TIMEOUT on timeout)
//   busy        high while a window or a report is outstanding
//   lock_err    sticky flag for a detector lock violation (optional check)
//
// Build option:
//   FSR_LOCK_CHECK_EN
//     Defined:   builds the lock check. If y_in differs from a non-zero
//                captured mask while the report is pending, lock_err is set.
//                It stays set until rst. The check never changes the FSM or
//                the report.
//     Undefined: lock_err is tied to 0 and no check logic is built.
// -----------------------------------------------------------------------------
module first_signal_reporter #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       y_in,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [1:0]       rpt_winner,
   output logic             rpt_tie,
   output logic [2:0]       rpt_mask,
   output logic [CNT_W-1:0] rpt_time,
   output logic             busy,
   output logic             lock_err
);

   // ---------------------------------------------------------------------------
   // FSM encoding
   // ---------------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_REPORT = 2'd2;

   // Last counter value before a timeout, and the time reported for a timeout.
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   // ---------------------------------------------------------------------------
   // Winner / tie encoding of a captured mask {c,b,a}
   // ---------------------------------------------------------------------------
   // Fixed priority a > b > c. An all-zero mask encodes as "none".
   function automatic logic [1:0] winner_of(input logic [2:0] m);
      logic [1:0] w;
      w = 2'd0;
      if (m[0]) begin
         w = 2'd1;
      end else if (m[1]) begin
         w = 2'd2;
      end else if (m[2]) begin
         w = 2'd3;
      end
      return w;
   endfunction

   // popcount(m) >= 2 is true exactly when some pair of bits is set.
   function automatic logic tie_of(input logic [2:0] m);
      return (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
   endfunction

   // ---------------------------------------------------------------------------
   // State and report registers
   // ---------------------------------------------------------------------------
   logic [1:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             valid_q,  valid_d;
   logic [1:0]       winner_q, winner_d;
   logic             tie_q,    tie_d;
   logic [2:0]       mask_q,   mask_d;
   logic [CNT_W-1:0] time_q,   time_d;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a hold default first, so no path leaves a
      // variable unassigned and no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      winner_d = winner_q;
      tie_d    = tie_q;
      mask_d   = mask_q;
      time_d   = time_q;

      case (state_q)
         ST_IDLE: begin
            // y_in is not looked at here. Only start opens a window.
            if (start) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end

         ST_WAIT: begin
            // A signal takes priority over a timeout on the same edge, so
            // y_in is tested before the counter.
            if (y_in != 3'b000) begin
               state_d  = ST_REPORT;
               valid_d  = 1'b1;
               mask_d   = y_in;
               winner_d = winner_of(y_in);
               tie_d    = tie_of(y_in);
               time_d   = cnt_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = ST_REPORT;
               valid_d  = 1'b1;
               mask_d   = 3'b000;
               winner_d = 2'd0;
               tie_d    = 1'b0;
               time_d   = CNT_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_REPORT: begin
            // The report fields hold until accepted. A start seen on the
            // accept edge is dropped, because the FSM is not in IDLE then.
            if (rpt_ready) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end

         default: begin
            // The fourth encoding is unreachable. If it ever appears, drop
            // back to IDLE with no report pending.
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only. Every flop
      // then samples pre-edge values and there are no simulation races.
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         winner_q <= 2'd0;
         tie_q    <= 1'b0;
         mask_q   <= 3'b000;
         time_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         winner_q <= winner_d;
         tie_q    <= tie_d;
         mask_q   <= mask_d;
         time_q   <= time_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // All report outputs come straight from flops. rpt_ready only changes
   // rpt_valid through the next edge, so there is no combinational path.
   assign rpt_valid  = valid_q;
   assign rpt_winner = winner_q;
   assign rpt_tie    = tie_q;
   assign rpt_mask   = mask_q;
   assign rpt_time   = time_q;
   assign busy       = (state_q != ST_IDLE);

   // ---------------------------------------------------------------------------
   // Optional detector lock check
   // ---------------------------------------------------------------------------
`ifdef FSR_LOCK_CHECK_EN
   logic lock_err_q, lock_err_d;

   // The capture moves the FSM straight to REPORT. The window after capture
   // is therefore exactly the REPORT state. A timeout report (mask 0) has
   // nothing locked, so it is exempt from the check.
   always_comb begin
      lock_err_d = lock_err_q;
      if ((state_q == ST_REPORT) && (mask_q != 3'b000) && (y_in != mask_q)) begin
         lock_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_err_q <= 1'b0;
      end else begin
         lock_err_q <= lock_err_d;
      end
   end

   assign lock_err = lock_err_q;
`else
   assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_first_signal_reporter.sv
// -----------------------------------------------------------------------------
// tb_first_signal_reporter
//
// Directed bench for first_signal_reporter, built with TIMEOUT = 8.
// Each scenario task drives its own stimulus and compares outputs against
// hand-computed values. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_first_signal_reporter;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned TIMEOUT = 8;

`ifdef FSR_LOCK_CHECK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [2:0]       y_in;
   logic             rpt_valid;
   logic             rpt_ready;
   logic [1:0]       rpt_winner;
   logic             rpt_tie;
   logic [2:0]       rpt_mask;
   logic [CNT_W-1:0] rpt_time;
   logic             busy;
   logic             lock_err;

   int checks   = 0;
   int failures = 0;

   first_signal_reporter #(
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .y_in      (y_in),
      .rpt_valid (rpt_valid),
      .rpt_ready (rpt_ready),
      .rpt_winner(rpt_winner),
      .rpt_tie   (rpt_tie),
      .rpt_mask  (rpt_mask),
      .rpt_time  (rpt_time),
      .busy      (busy),
      .lock_err  (lock_err)
   );

   always #5 clk = ~clk;

   // Snapshot layout: {valid, winner, tie, mask, time, busy}, 24 bits.
   function automatic logic [23:0] obs();
      return {rpt_valid, rpt_winner, rpt_tie, rpt_mask, rpt_time, busy};
   endfunction

   function automatic logic [23:0] mk(input logic v, input logic [1:0] w,
                                      input logic t, input logic [2:0] m,
                                      input logic [15:0] tm, input logic b);
      return {v, w, t, m, tm, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [23:0] o;
      rst = 1'b1; start = 1'b0; y_in = 3'b000; rpt_ready = 1'b0;
      tick(); tick();
      o = obs();
      checks++;
      if (o !== mk(1'b0, 2'd0, 1'b0, 3'b000, 16'd0, 1'b0)) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected %h", o, mk(1'b0, 2'd0, 1'b0, 3'b000, 16'd0, 1'b0));
      end
      checks++;
      if (lock_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_lock_err: got %b expected 0", lock_err);
      end
      rst = 1'b0;
      tick();
   endtask

   // Start at edge s, y_in = 010 first sampled at edge s+5 -> time 4.
   task automatic test_single_winner();
      logic [23:0] o;
      start = 1'b1;
      tick();                         // edge s
      start = 1'b0;
      o = obs();
      checks++;
      if (o !== mk(1'b0, 2'd0, 1'b0, 3'b000, 16'd0, 1'b1)) begin
         failures++;
         $display("FAIL single_busy_after_start: got %h expected %h", o, mk(1'b0, 2'd0, 1'b0, 3'b000, 16'd0, 1'b1));
      end
      for (int i = 0; i < 4; i++) tick();   // edges s+1 .. s+4, y_in = 0
      checks++;
      if (rpt_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_valid_early: got %b expected 0", rpt_valid);
      end
      y_in = 3'b010;
      tick();                         // edge s+5 = k
      o = obs();
      checks++;
      if (o !== mk(1'b1, 2'd2, 1'b0, 3'b010, 16'd4, 1'b1)) begin
         failures++;
         $display("FAIL single_report: got %h expected %h", o, mk(1'b1, 2'd2, 1'b0, 3'b010, 16'd4, 1'b1));
      end
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      o = obs();
      checks++;
      if (o[23] !== 1'b0 || o[0] !== 1'b0) begin
         failures++;
         $display("FAIL single_accept: got valid=%b busy=%b expected 0 0", o[23], o[0]);
      end
      y_in = 3'b000;
   endtask

   // y_in = 101 at the first WAIT sample, ready held low for 5 cycles.
   task automatic test_tie_backpressure();
      logic [23:0] o;
      start = 1'b1;
      tick();
      start = 1'b0;
      y_in  = 3'b101;
      tick();
      o = obs();
      checks++;
      if (o !== mk(1'b1, 2'd1, 1'b1, 3'b101, 16'd0, 1'b1)) begin
         failures++;
         $display("FAIL tie_report: got %h expected %h", o, mk(1'b1, 2'd1, 1'b1, 3'b101, 16'd0, 1'b1));
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         o = obs();
         checks++;
         if (o !== mk(1'b1, 2'd1, 1'b1, 3'b101, 16'd0, 1'b1)) begin
            failures++;
            $display("FAIL tie_hold_%0d: got %h expected %h", i, o, mk(1'b1, 2'd1, 1'b1, 3'b101, 16'd0, 1'b1));
         end
      end
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      checks++;
      if (rpt_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL tie_accept: got valid=%b busy=%b expected 0 0", rpt_valid, busy);
      end
      y_in = 3'b000;
   endtask

   // TIMEOUT = 8: no signal gives time 8. A signal on the 8th edge gives time 7.
   task automatic test_timeout();
      logic [23:0] o;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      checks++;
      if (rpt_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL timeout_early: got valid=%b busy=%b expected 0 1", rpt_valid, busy);
      end
      tick();                         // edge s+8
      o = obs();
      checks++;
      if (o !== mk(1'b1, 2'd0, 1'b0, 3'b000, 16'd8, 1'b1)) begin
         failures++;
         $display("FAIL timeout_report: got %h expected %h", o, mk(1'b1, 2'd0, 1'b0, 3'b000, 16'd8, 1'b1));
      end
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      y_in = 3'b001;
      tick();                         // 8th edge: signal beats timeout
      o = obs();
      checks++;
      if (o !== mk(1'b1, 2'd1, 1'b0, 3'b001, 16'd7, 1'b1)) begin
         failures++;
         $display("FAIL timeout_signal_wins: got %h expected %h", o, mk(1'b1, 2'd1, 1'b0, 3'b001, 16'd7, 1'b1));
      end
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      y_in = 3'b000;
   endtask

   // Start pulses during WAIT, during REPORT and on the accept edge are dropped.
   task automatic test_ignored_starts();
      logic [23:0] o;
      start = 1'b1;
      tick();                         // edge s opens the window
      tick(); tick();                 // starts in WAIT, cnt -> 2
      y_in = 3'b100;
      tick();                         // capture at cnt 2
      o = obs();
      checks++;
      if (o !== mk(1'b1, 2'd3, 1'b0, 3'b100, 16'd2, 1'b1)) begin
         failures++;
         $display("FAIL ign_report: got %h expected %h", o, mk(1'b1, 2'd3, 1'b0, 3'b100, 16'd2, 1'b1));
      end
      tick();                         // start in REPORT
      o = obs();
      checks++;
      if (o !== mk(1'b1, 2'd3, 1'b0, 3'b100, 16'd2, 1'b1)) begin
         failures++;
         $display("FAIL ign_report_hold: got %h expected %h", o, mk(1'b1, 2'd3, 1'b0, 3'b100, 16'd2, 1'b1));
      end
      rpt_ready = 1'b1;
      tick();                         // accept edge with start high
      start = 1'b0;
      rpt_ready = 1'b0;
      checks++;
      if (rpt_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ign_accept_start: got valid=%b busy=%b expected 0 0", rpt_valid, busy);
      end
      tick();
      checks++;
      if (rpt_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ign_idle_after: got valid=%b busy=%b expected 0 0", rpt_valid, busy);
      end
      y_in = 3'b000;
   endtask

   // Ready held high throughout: start, capture, accept every 3 cycles.
   task automatic test_back_to_back();
      logic [23:0] o;
      rpt_ready = 1'b1;
      y_in = 3'b010;
      for (int n = 0; n < 2; n++) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         checks++;
         if (rpt_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_open_%0d: got valid=%b busy=%b expected 0 1", n, rpt_valid, busy);
         end
         tick();
         o = obs();
         checks++;
         if (o !== mk(1'b1, 2'd2, 1'b0, 3'b010, 16'd0, 1'b1)) begin
            failures++;
            $display("FAIL b2b_report_%0d: got %h expected %h", n, o, mk(1'b1, 2'd2, 1'b0, 3'b010, 16'd0, 1'b1));
         end
         tick();
         checks++;
         if (rpt_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept_%0d: got valid=%b busy=%b expected 0 0", n, rpt_valid, busy);
         end
      end
      rpt_ready = 1'b0;
      y_in = 3'b000;
   endtask

   // Reset while a report is pending, then a clean new window.
   task automatic test_mid_reset();
      logic [23:0] o;
      start = 1'b1;
      tick();
      start = 1'b0;
      y_in = 3'b011;
      tick();
      checks++;
      if (rpt_valid !== 1'b1 || rpt_winner !== 2'd1 || rpt_tie !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre_reset: got valid=%b winner=%0d tie=%b expected 1 1 1", rpt_valid, rpt_winner, rpt_tie);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      y_in = 3'b000;
      o = obs();
      checks++;
      if (o !== mk(1'b0, 2'd0, 1'b0, 3'b000, 16'd0, 1'b0)) begin
         failures++;
         $display("FAIL mid_after_reset: got %h expected %h", o, mk(1'b0, 2'd0, 1'b0, 3'b000, 16'd0, 1'b0));
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();                         // cnt -> 1
      y_in = 3'b001;
      tick();
      o = obs();
      checks++;
      if (o !== mk(1'b1, 2'd1, 1'b0, 3'b001, 16'd1, 1'b1)) begin
         failures++;
         $display("FAIL mid_new_window: got %h expected %h", o, mk(1'b1, 2'd1, 1'b0, 3'b001, 16'd1, 1'b1));
      end
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      y_in = 3'b000;
   endtask

   // Capture 001, then drive 011 during REPORT.
   task automatic test_lock_check();
      logic [23:0] o;
      checks++;
      if (lock_err !== 1'b0) begin
         failures++;
         $display("FAIL lock_initial: got %b expected 0", lock_err);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      y_in = 3'b001;
      tick();
      y_in = 3'b011;
      tick();
      o = obs();
      checks++;
      if (lock_err !== LOCK_EN) begin
         failures++;
         $display("FAIL lock_set: got %b expected %b", lock_err, LOCK_EN);
      end
      checks++;
      if (o !== mk(1'b1, 2'd1, 1'b0, 3'b001, 16'd0, 1'b1)) begin
         failures++;
         $display("FAIL lock_report_unchanged: got %h expected %h", o, mk(1'b1, 2'd1, 1'b0, 3'b001, 16'd0, 1'b1));
      end
      rpt_ready = 1'b1;
      tick();
      rpt_ready = 1'b0;
      y_in = 3'b000;
      tick();
      checks++;
      if (lock_err !== LOCK_EN || rpt_valid !== 1'b0) begin
         failures++;
         $display("FAIL lock_sticky: got lock_err=%b valid=%b expected %b 0", lock_err, rpt_valid, LOCK_EN);
      end
   endtask

   initial begin
      test_reset();
      test_single_winner();
      test_tie_backpressure();
      test_timeout();
      test_ignored_starts();
      test_back_to_back();
      test_mid_reset();
      test_lock_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/first_signal_reporter.md
# first_signal_reporter

Downstream consumer of the first-signal detector. It turns the detector's locked one-hot/multi-hot capture `y` into a single timestamped report per measurement window. A window opens on a `start` pulse, measures the cycles until the detector output goes non-zero (or a timeout expires), encodes the winner and any tie, and presents the result on a valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, default 16: width of the arrival-time counter and `rpt_time`.
- `TIMEOUT`, default 1000: cycles in a window before a no-signal report is issued. Legal range is 1 ≤ TIMEOUT ≤ 2^CNT_W − 1.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: single-cycle request to open a measurement window.
- `y_in`  in  3: detector capture `{c,b,a}`, locked once non-zero.
- `rpt_valid`  out  1: report available.
- `rpt_ready`  in  1: consumer accepts the report.
- `rpt_winner`  out  2: 0 = timeout/none, 1 = a, 2 = b, 3 = c.
- `rpt_tie`  out  1: more than one bit set in the captured mask.
- `rpt_mask`  out  3: raw captured `y_in`.
- `rpt_time`  out  CNT_W: cycles from window open to capture.
- `busy`  out  1: high in WAIT and REPORT.
- `lock_err`  out  1: sticky error for detector lock violation (see Configuration).

## Operation
- FSM states: IDLE, WAIT, REPORT.
- **IDLE**
  - `start`=1 → WAIT, counter cleared to 0.
  - `y_in` is ignored in IDLE.
- **WAIT**
  - If `y_in`≠0: capture `rpt_mask`=`y_in`, `rpt_time`=counter, go to REPORT.
  - Else if counter==TIMEOUT−1: `rpt_mask`=0, `rpt_winner`=0, `rpt_tie`=0, `rpt_time`=TIMEOUT, go to REPORT.
  - Else the counter increments by 1.
  - The counter never wraps, because TIMEOUT < 2^CNT_W.
- **REPORT**
  - `rpt_valid`=1.
  - All `rpt_*` fields are held stable until `rpt_ready`=1 at a rising edge. Then go to IDLE and clear `rpt_valid`.
- Winner encoding is a fixed priority a > b > c on the captured mask.
  - Example: mask 3'b110 gives winner=2 and tie=1.
  - Tie is set when popcount(mask) ≥ 2.
- `start` is ignored outside IDLE. This includes a `start` in the same cycle as the REPORT handshake.
- `busy` = (state≠IDLE).

## Timing
- Reset values:
  - State IDLE; `rpt_valid`=0, `rpt_winner`=0, `rpt_tie`=0, `rpt_mask`=0, `rpt_time`=0, `busy`=0, `lock_err`=0.
  - The counter resets to 0.
- Window timing:
  - `start` sampled at edge s → WAIT after s.
  - First `y_in` sample at edge s+1, which gives `rpt_time`=0.
  - A non-zero `y_in` first sampled at edge k gives `rpt_time`=k−s−1, with `rpt_valid` high after edge k (1-cycle latency, registered outputs).
  - Timeout: with no signal, `rpt_valid` rises after edge s+TIMEOUT.
- Handshake:
  - Transfer occurs on an edge where `rpt_valid`&&`rpt_ready`.
  - `rpt_valid` falls after that edge.
  - `rpt_ready` may be high before valid; there is no combinational path from `rpt_ready` to `rpt_valid`.
  - Minimum back-to-back period is 3 cycles (start, capture, accept).
- `y_in` going non-zero on the same edge that the counter hits TIMEOUT−1 produces a signal report, not a timeout: signal wins.
- `rst` asserted in any state → IDLE and all outputs at reset values after that edge. A pending report is discarded.

## Configuration
- `FSR_LOCK_CHECK_EN` defined:
  - While in WAIT after capture, or in REPORT, a sampled `y_in` differing from `rpt_mask` (non-zero capture only) sets `lock_err`=1.
  - `lock_err` stays set until `rst`.
  - It does not affect the FSM or the report.
- `FSR_LOCK_CHECK_EN` undefined: `lock_err` is tied to 0 and no check logic is built.

## Test plan
- Single winner: `start` at edge 10, `y_in`=3'b010 from edge 15 → report winner=2, tie=0, mask=3'b010, time=4, `rpt_valid` after edge 15.
- Tie plus backpressure: `y_in`=3'b101 at first WAIT sample, `rpt_ready` low for 5 cycles → winner=1, tie=1, time=0; fields stable for all 5 cycles, then `rpt_valid` clears one edge after `rpt_ready`=1.
- Timeout with TIMEOUT=8: `start`, `y_in`=0 throughout → after 8 edges winner=0, mask=0, time=8. Repeat with `y_in`=3'b001 arriving on the 8th edge → winner=1, time=7.
- Ignored starts: `start` pulses during WAIT and REPORT, and on the accept edge → exactly one report; state IDLE afterwards.
- Mid-operation reset: `rst` for 1 cycle while in REPORT with `rpt_ready`=0 → `rpt_valid`=0 and `busy`=0 next cycle; a new `start` then works normally.
- With `FSR_LOCK_CHECK_EN`: capture 3'b001, then drive 3'b011 while in REPORT → `lock_err`=1 and it stays set after the handshake. Without the macro → `lock_err` stays 0.
